mux16_1_8b_struc: RTL and testbench
===================================

MUX16_1_8B_STRUC -- requirements
Module: mux16_1_8b_struc

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every input word and output.
REQ-002 clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A..P  input  WIDTH each (16 ports, in order A,B,C,...,P)  data words 0..15.
REQ-005 S3  input  1  select bit 3 (MSB).
REQ-006 S2  input  1  select bit 2.
REQ-007 S1  input  1  select bit 1.
REQ-008 S0  input  1  select bit 0 (LSB).
REQ-009 Salida  output  WIDTH  combinational selected word.
REQ-010 Salida_r  output  WIDTH  registered copy of Salida.
REQ-011 Port order SHALL be clk, rst, A..P, S3, S2, S1, S0, Salida, Salida_r.

Function
REQ-012 Select index SHALL be sel = {S3,S2,S1,S0}, unsigned 0..15.
REQ-013 Salida SHALL equal the input word at position sel: 0->A, 1->B, ..., 14->O, 15->P.
REQ-014 Salida SHALL be purely combinational, with no clock dependency and zero cycles of latency.
REQ-015 Salida SHALL settle within 1 ns of any data or select change in zero-delay simulation.
REQ-016 All WIDTH bits SHALL be switched by the same select; there is no per-bit mixing.
REQ-017 Salida_r SHALL load Salida on every rising clk edge when rst=0, giving exactly one cycle of latency.
REQ-018 When a select or data change coincides with a clock edge, Salida_r SHALL capture the value present before the edge.
REQ-019 Any X/Z on a select bit SHALL NOT be resolved by the block; propagation follows gate semantics.

Reset
REQ-020 When rst=1 at a rising clk edge, Salida_r SHALL become all zeros.
REQ-021 rst SHALL NOT affect Salida.
REQ-022 If rst is asserted mid-operation, Salida_r SHALL be zero on the following edge and SHALL resume tracking on the first edge after rst=0.
REQ-023 Salida_r is undefined before the first clock edge.

Structure
REQ-024 No shared package is required; WIDTH is a local parameter and select width is fixed at 4.
REQ-025 The combinational path SHALL be structural: a tree of 15 instances of a sub-module mux2_1_8b (WIDTH-bit 2:1 mux).
REQ-026 The mux tree SHALL have four levels:
- level 1: eight mux2_1_8b on S0;
- level 2: four on S1;
- level 3: two on S2;
- level 4: one on S3.
REQ-027 mux2_1_8b SHALL be gate-level per bit: out = (~s & a) | (s & b).
REQ-028 The output register SHALL be a single always block clocked on posedge clk, with synchronous rst.

Verification
REQ-029 Common data set for all scenarios:
- A=00000000, B=00000001, C=11111111, D=11111110;
- E=11111101, F=11111100, G=00000010, H=00000011;
- I=01100001, J=01100010, K=01100011, L=10010000;
- M=10010001, N=10010010, O=10010011, P=11110000.
REQ-030 With the data set, S3..S0=1110 -> Salida=10010011 (O) within 1 ns.
REQ-031 Sweep sel 0..15 -> Salida matches A..P in order, e.g. sel=0 -> 00000000, sel=2 -> 11111111, sel=15 -> 11110000.
REQ-032 rst=1 for 2 cycles, then rst=0 with sel=8 -> Salida_r=00000000 during reset and 01100001 one edge after release; Salida=01100001 throughout.
REQ-033 Change sel from 3 to 12 just before an edge -> Salida=10010001 immediately, Salida_r=10010001 after that edge, not before.
REQ-034 Hold sel=5 and change F from 11111100 to 10101010 -> Salida follows within 1 ns; Salida_r follows on the next edge.
REQ-035 Assert rst mid-sweep at sel=7 -> Salida_r=0 on the next edge while Salida stays 00000011.

Source files
------------

// File: rtl/mux16_1_8b_struc_pkg.sv
// Shared constants for the 16:1 structural mux.
//   SEL_W  : select width (fixed at 4)
//   NUM_IN : number of data words (16)
package mux16_1_8b_struc_pkg;
  localparam int SEL_W  = 4;
  localparam int NUM_IN = 1 << SEL_W;
endpackage

// File: rtl/mux2_1_8b.sv
// WIDTH-bit 2:1 mux built from per-bit AND/OR gates.
//   s   : select (0 -> a, 1 -> b)
//   a,b : data words
//   out : selected word
// X/Z on s is left to gate semantics, not resolved.
module mux2_1_8b #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign out[i] = (~s & a[i]) | (s & b[i]);
  end
endmodule

// File: rtl/mux16_1_8b_struc.sv
// 16:1 WIDTH-bit mux as a 4-level tree of 2:1 muxes, plus a registered copy.
//   clk, rst     : clock, synchronous active-high reset (clears Salida_r only)
//   A..P         : data words 0..15
//   S3..S0       : select, S3 is MSB
//   Salida       : combinational selected word
//   Salida_r     : Salida delayed by one clock
module mux16_1_8b_struc
  import mux16_1_8b_struc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] O,
  input  logic [WIDTH-1:0] P,
  input  logic             S3,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  output logic [WIDTH-1:0] Salida,
  output logic [WIDTH-1:0] Salida_r
);
  // din[k] is data word k, so adjacent pairs differ only in S0.
  logic [NUM_IN-1:0][WIDTH-1:0] din;
  logic [7:0][WIDTH-1:0]        l1;
  logic [3:0][WIDTH-1:0]        l2;
  logic [1:0][WIDTH-1:0]        l3;

  assign din = {P, O, N, M, L, K, J, I, H, G, F, E, D, C, B, A};

  // level 1: pairs on S0
  for (genvar gi = 0; gi < 8; gi++) begin : g_l1
    mux2_1_8b #(.WIDTH(WIDTH)) u_mux (
      .s(S0), .a(din[2*gi]), .b(din[2*gi+1]), .out(l1[gi])
    );
  end

  // level 2: on S1
  for (genvar gi = 0; gi < 4; gi++) begin : g_l2
    mux2_1_8b #(.WIDTH(WIDTH)) u_mux (
      .s(S1), .a(l1[2*gi]), .b(l1[2*gi+1]), .out(l2[gi])
    );
  end

  // level 3: on S2
  for (genvar gi = 0; gi < 2; gi++) begin : g_l3
    mux2_1_8b #(.WIDTH(WIDTH)) u_mux (
      .s(S2), .a(l2[2*gi]), .b(l2[2*gi+1]), .out(l3[gi])
    );
  end

  // level 4: root on S3
  mux2_1_8b #(.WIDTH(WIDTH)) u_root (
    .s(S3), .a(l3[0]), .b(l3[1]), .out(Salida)
  );

  always_ff @(posedge clk) begin
    if (rst) Salida_r <= '0;
    else     Salida_r <= Salida;
  end
endmodule

// File: tb/tb_mux16_1_8b_struc.sv
// Randomized + directed bench for mux16_1_8b_struc with a scoreboard queue.
// Stimulus changes on falling edges; the monitor checks the combinational
// output 1 ns later and the register just after each rising edge.
module tb_mux16_1_8b_struc;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B, C, D, E, F, G, H, I, J, K, L, M, N, O, P;
  logic       S3, S2, S1, S0;
  logic [7:0] Salida, Salida_r;

  mux16_1_8b_struc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .I(I), .J(J), .K(K), .L(L), .M(M), .N(N), .O(O), .P(P),
    .S3(S3), .S2(S2), .S1(S1), .S0(S0),
    .Salida(Salida), .Salida_r(Salida_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;         // expected Salida
    logic [7:0] rb;        // expected Salida_r before the edge
    bit         rb_known;  // register state defined yet
    logic [7:0] ra;        // expected Salida_r after the edge
  } exp_t;

  exp_t       q[$];
  logic [7:0] dat [16];
  logic [7:0] rmodel;
  bit         rknown = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: output is simply the word at index sel; the register holds
  // the previous cycle's word, or zero if reset was high at the edge.
  task automatic drive(input logic [3:0] sel, input bit r);
    exp_t e;
    @(negedge clk);
    {A, B, C, D, E, F, G, H} = {dat[0], dat[1], dat[2], dat[3], dat[4], dat[5], dat[6], dat[7]};
    {I, J, K, L, M, N, O, P} = {dat[8], dat[9], dat[10], dat[11], dat[12], dat[13], dat[14], dat[15]};
    {S3, S2, S1, S0} = sel;
    rst = r;
    e.c        = dat[sel];
    e.rb       = rmodel;
    e.rb_known = rknown;
    e.ra       = r ? 8'h00 : dat[sel];
    rmodel     = e.ra;
    rknown     = 1'b1;
    q.push_back(e);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (q.size() > 0) begin
        chk("comb_1ns", Salida, q[0].c);
        if (q[0].rb_known) chk("reg_before_edge", Salida_r, q[0].rb);
      end
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("comb_after_edge", Salida, e.c);
        chk("reg_after_edge", Salida_r, e.ra);
      end
    end
  end

  initial begin
    logic [3:0] s;
    rst = 1'b1;
    {S3, S2, S1, S0} = 4'd0;
    dat = '{8'b00000000, 8'b00000001, 8'b11111111, 8'b11111110,
            8'b11111101, 8'b11111100, 8'b00000010, 8'b00000011,
            8'b01100001, 8'b01100010, 8'b01100011, 8'b10010000,
            8'b10010001, 8'b10010010, 8'b10010011, 8'b11110000};
    {A, B, C, D, E, F, G, H} = '0;
    {I, J, K, L, M, N, O, P} = '0;

    // reset two cycles with sel=8, then release
    drive(4'd8, 1'b1);
    drive(4'd8, 1'b1);
    drive(4'd8, 1'b0);
    drive(4'd8, 1'b0);
    // select O
    drive(4'd14, 1'b0);
    // full sweep
    for (int k = 0; k < 16; k++) drive(k[3:0], 1'b0);
    // sel 3 -> 12 before an edge
    drive(4'd3, 1'b0);
    drive(4'd12, 1'b0);
    // hold sel=5, change F
    drive(4'd5, 1'b0);
    dat[5] = 8'b10101010;
    drive(4'd5, 1'b0);
    drive(4'd5, 1'b0);
    // reset mid-sweep at sel=7
    for (int k = 0; k < 7; k++) drive(k[3:0], 1'b0);
    drive(4'd7, 1'b1);
    drive(4'd7, 1'b0);
    drive(4'd8, 1'b0);
    // random phase
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 16; k++) dat[k] = 8'($urandom);
      s = 4'($urandom_range(0, 15));
      drive(s, ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
